// File: rtl/dm_arbiter_if.sv
// Bundle of both master request/response channels and the data-memory port.
// The arbiter uses the slave view; a requester/memory model uses the master view.
interface dm_arbiter_if #(
    parameter int unsigned MEM_AW = 12
);
    logic              m0_req;
    logic              m0_we;
    logic [1:0]        m0_size;
    logic              m0_sext;
    logic [31:0]       m0_addr;
    logic [31:0]       m0_wdata;
    logic              m0_ack;
    logic              m0_err;
    logic [31:0]       m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [1:0]        m1_size;
    logic              m1_sext;
    logic [31:0]       m1_addr;
    logic [31:0]       m1_wdata;
    logic              m1_ack;
    logic              m1_err;
    logic [31:0]       m1_rdata;

    logic              mem_en;
    logic [3:0]        mem_be;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    modport slave (
        input  m0_req, m0_we, m0_size, m0_sext, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_size, m1_sext, m1_addr, m1_wdata,
        output m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata,
        output mem_en, mem_be, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output m0_req, m0_we, m0_size, m0_sext, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_size, m1_sext, m1_addr, m1_wdata,
        input  m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata,
        input  mem_en, mem_be, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/dm_arbiter.sv
// Two-master data-memory arbiter: grants one access at a time, drives lane enables and
// replicated store data, waits on mem_ready and returns right-aligned, extended load data.
module dm_arbiter #(
    parameter int unsigned MEM_AW = 12,
    parameter bit          RR     = 1'b1
) (
    input logic          clk_i,
    input logic          rst_ni,
    dm_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e              state_q;
    logic                last_q;
    logic                gnt_q;
    logic                we_q;
    logic                sext_q;
    logic [1:0]          size_q;
    logic [1:0]          lo_q;
    logic                mem_en_q;
    logic [3:0]          mem_be_q;
    logic [MEM_AW-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;
    logic [1:0]          ack_q;
    logic [1:0]          err_q;
    logic [31:0]         rdata0_q;
    logic [31:0]         rdata1_q;

    logic                any_req;
    logic                sel;
    logic                sel_we;
    logic                sel_sext;
    logic [1:0]          sel_size;
    logic [MEM_AW+1:0]   sel_addr;
    logic [31:0]         sel_wdata;
    logic                sel_legal;
    logic [3:0]          sel_be;
    logic [31:0]         sel_wrep;
    logic [31:0]         lane;
    logic [31:0]         load_data;

    always_comb begin
        any_req = bus.m0_req | bus.m1_req;
        // On a tie the pointer names the last winner, so the other master goes next.
        if (bus.m0_req && bus.m1_req) begin
            sel = RR ? ~last_q : 1'b0;
        end else begin
            sel = ~bus.m0_req;
        end
        sel_we    = sel ? bus.m1_we    : bus.m0_we;
        sel_sext  = sel ? bus.m1_sext  : bus.m0_sext;
        sel_size  = sel ? bus.m1_size  : bus.m0_size;
        sel_addr  = sel ? bus.m1_addr[MEM_AW+1:0] : bus.m0_addr[MEM_AW+1:0];
        sel_wdata = sel ? bus.m1_wdata : bus.m0_wdata;
    end

    always_comb begin
        sel_legal = 1'b0;
        sel_be    = 4'b0000;
        sel_wrep  = sel_wdata;
        case (sel_size)
            2'b00: begin
                sel_legal = 1'b1;
                sel_be    = 4'b0001 << sel_addr[1:0];
                sel_wrep  = {4{sel_wdata[7:0]}};
            end
            2'b01: begin
                sel_legal = ~sel_addr[0];
                sel_be    = sel_addr[1] ? 4'b1100 : 4'b0011;
                sel_wrep  = {2{sel_wdata[15:0]}};
            end
            2'b10: begin
                sel_legal = (sel_addr[1:0] == 2'b00);
                sel_be    = 4'b1111;
            end
            default: begin
                sel_legal = 1'b0;
            end
        endcase
        if (!sel_we) begin
            sel_be = 4'b0000;
        end
    end

    always_comb begin
        lane      = bus.mem_rdata >> {lo_q, 3'b000};
        load_data = bus.mem_rdata;
        case (size_q)
            2'b00:   load_data = {{24{sext_q & lane[7]}}, lane[7:0]};
            2'b01:   load_data = {{16{sext_q & lane[15]}}, lane[15:0]};
            default: load_data = bus.mem_rdata;
        endcase
        if (we_q) begin
            load_data = 32'h0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            last_q      <= 1'b1;
            gnt_q       <= 1'b0;
            we_q        <= 1'b0;
            sext_q      <= 1'b0;
            size_q      <= 2'b00;
            lo_q        <= 2'b00;
            mem_en_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
            ack_q       <= 2'b00;
            err_q       <= 2'b00;
            rdata0_q    <= 32'h0;
            rdata1_q    <= 32'h0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (any_req) begin
                        gnt_q  <= sel;
                        last_q <= sel;
                        we_q   <= sel_we;
                        sext_q <= sel_sext;
                        size_q <= sel_size;
                        lo_q   <= sel_addr[1:0];
                        if (sel_legal) begin
                            state_q     <= StAccess;
                            mem_en_q    <= 1'b1;
                            mem_be_q    <= sel_be;
                            mem_addr_q  <= sel_addr[MEM_AW+1:2];
                            mem_wdata_q <= sel_wrep;
                        end else begin
                            state_q    <= StDone;
                            ack_q[sel] <= 1'b1;
                            err_q[sel] <= 1'b1;
                        end
                    end
                end
                StAccess: begin
                    if (bus.mem_ready) begin
                        state_q      <= StDone;
                        mem_en_q     <= 1'b0;
                        mem_be_q     <= 4'b0000;
                        mem_addr_q   <= '0;
                        mem_wdata_q  <= 32'h0;
                        ack_q[gnt_q] <= 1'b1;
                        if (gnt_q) begin
                            rdata1_q <= load_data;
                        end else begin
                            rdata0_q <= load_data;
                        end
                    end
                end
                StDone: begin
                    state_q  <= StIdle;
                    ack_q    <= 2'b00;
                    err_q    <= 2'b00;
                    rdata0_q <= 32'h0;
                    rdata1_q <= 32'h0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.m0_ack    = ack_q[0];
    assign bus.m1_ack    = ack_q[1];
    assign bus.m0_err    = err_q[0];
    assign bus.m1_err    = err_q[1];
    assign bus.m0_rdata  = rdata0_q;
    assign bus.m1_rdata  = rdata1_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: transaction-level reference model checked every cycle, directed
// scenarios with literal expectations, randomized two-master traffic and a fixed-priority DUT.
module tb_dm_arbiter;

    localparam int unsigned AW      = 12;
    localparam bit          RR_MAIN = 1'b1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dm_arbiter_if #(.MEM_AW(AW)) bus ();
    dm_arbiter_if #(.MEM_AW(AW)) fbus ();

    dm_arbiter #(.MEM_AW(AW), .RR(1'b1)) u_dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
    dm_arbiter #(.MEM_AW(AW), .RR(1'b0)) u_fp  (.clk_i(clk), .rst_ni(rst_n), .bus(fbus));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit is_legal(input logic [1:0] s, input logic [31:0] a);
        if (s == 2'd3) return 1'b0;
        return (int'(a[1:0]) % nbytes(s)) == 0;
    endfunction

    function automatic logic [3:0] exp_be(input bit we, input logic [1:0] s, input logic [31:0] a);
        int v;
        if (!we) return 4'b0000;
        v = ((1 << nbytes(s)) - 1) << int'(a[1:0]);
        return v[3:0];
    endfunction

    function automatic logic [31:0] exp_wrep(input logic [1:0] s, input logic [31:0] w);
        if (s == 2'd0) return (w & 32'hFF) * 32'h0101_0101;
        if (s == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] s, input bit sx, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * int'(a[1:0]));
        if (s == 2'd0) begin
            v = v & 32'hFF;
            if (sx) v = (v ^ 32'h80) - 32'h80;
        end else if (s == 2'd1) begin
            v = v & 32'hFFFF;
            if (sx) v = (v ^ 32'h8000) - 32'h8000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    typedef struct {
        int          m;
        bit          we;
        logic [1:0]  size;
        bit          sext;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t        t;
    bit          m_busy;
    bit          m_reply;
    bit          m_err;
    int          m_last;
    logic [31:0] m_rd;

    int          p_m;
    bit          p_we;
    bit          p_sext;
    logic [1:0]  p_size;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;

    always_comb begin
        p_m = 0;
        if (bus.m0_req && bus.m1_req) p_m = RR_MAIN ? 1 - m_last : 0;
        else if (!bus.m0_req)         p_m = 1;
        p_we    = (p_m == 1) ? bus.m1_we    : bus.m0_we;
        p_sext  = (p_m == 1) ? bus.m1_sext  : bus.m0_sext;
        p_size  = (p_m == 1) ? bus.m1_size  : bus.m0_size;
        p_addr  = (p_m == 1) ? bus.m1_addr  : bus.m0_addr;
        p_wdata = (p_m == 1) ? bus.m1_wdata : bus.m0_wdata;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_reply <= 1'b0;
            m_err   <= 1'b0;
            m_last  <= 1;
            m_rd    <= 32'h0;
            t.m     <= 0;
        end else if (m_reply) begin
            m_reply <= 1'b0;
        end else if (m_busy) begin
            if (bus.mem_ready) begin
                m_busy  <= 1'b0;
                m_reply <= 1'b1;
                m_err   <= 1'b0;
                m_rd    <= t.we ? 32'h0 : exp_load(t.size, t.sext, t.addr, bus.mem_rdata);
            end
        end else if (bus.m0_req || bus.m1_req) begin
            t.m     <= p_m;
            t.we    <= p_we;
            t.size  <= p_size;
            t.sext  <= p_sext;
            t.addr  <= p_addr;
            t.wdata <= p_wdata;
            m_last  <= p_m;
            if (is_legal(p_size, p_addr)) begin
                m_busy <= 1'b1;
            end else begin
                m_reply <= 1'b1;
                m_err   <= 1'b1;
                m_rd    <= 32'h0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int          mem_mode;
    logic [31:0] fix_rdata;
    int          en_cnt;
    int          unstable;
    bit          prev_en;
    logic [3:0]  cap_be;
    logic [31:0] cap_wd;
    logic [AW-1:0] cap_addr;
    int          fp_m0;
    int          fp_m1;

    task automatic drive(input int m, input bit we, input logic [1:0] size, input bit sx,
                         input logic [31:0] addr, input logic [31:0] wd);
        @(posedge clk);
        #1;
        if (m == 0) begin
            bus.m0_we = we; bus.m0_size = size; bus.m0_sext = sx;
            bus.m0_addr = addr; bus.m0_wdata = wd; bus.m0_req = 1'b1;
        end else begin
            bus.m1_we = we; bus.m1_size = size; bus.m1_sext = sx;
            bus.m1_addr = addr; bus.m1_wdata = wd; bus.m1_req = 1'b1;
        end
    endtask

    task automatic wait_ack(input int m, output int lat, output bit err, output logic [31:0] rd);
        lat = 0;
        err = 1'b0;
        rd  = 32'h0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if ((m == 0) ? bus.m0_ack : bus.m1_ack) begin
                err = (m == 0) ? bus.m0_err : bus.m1_err;
                rd  = (m == 0) ? bus.m0_rdata : bus.m1_rdata;
                if (m == 0) bus.m0_req = 1'b0; else bus.m1_req = 1'b0;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL ack_timeout m%0d: got no ack expected ack within 60 cycles", m);
        if (m == 0) bus.m0_req = 1'b0; else bus.m1_req = 1'b0;
        lat = -1;
    endtask

    task automatic rand_master(input int m, input int n);
        int          lat;
        bit          err;
        logic [31:0] rd;
        logic [31:0] a;
        logic [1:0]  s;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            s = 2'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (s == 2'd1) a[0] = 1'b0;
                if (s == 2'd2) a[1:0] = 2'b00;
            end
            drive(m, 1'($urandom), s, 1'($urandom), a, $urandom);
            wait_ack(m, lat, err, rd);
        end
    endtask

    // ---------------- main ----------------
    initial begin
        int          lat;
        bit          err;
        logic [31:0] rd;
        int          e0;
        int          u0;
        int          log_q[$];
        bit          seen;

        rst_n = 1'b0;
        {bus.m0_req, bus.m0_we, bus.m0_size, bus.m0_sext, bus.m0_addr, bus.m0_wdata} = '0;
        {bus.m1_req, bus.m1_we, bus.m1_size, bus.m1_sext, bus.m1_addr, bus.m1_wdata} = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        fbus.m0_req = 1'b1; fbus.m0_we = 1'b0; fbus.m0_size = 2'd2; fbus.m0_sext = 1'b0;
        fbus.m0_addr = 32'h0; fbus.m0_wdata = 32'h0;
        fbus.m1_req = 1'b1; fbus.m1_we = 1'b0; fbus.m1_size = 2'd2; fbus.m1_sext = 1'b0;
        fbus.m1_addr = 32'h4; fbus.m1_wdata = 32'h0;
        fbus.mem_ready = 1'b1; fbus.mem_rdata = 32'h1234_5678;
        mem_mode = 1; fix_rdata = 32'h0;
        en_cnt = 0; unstable = 0; prev_en = 1'b0;
        cap_be = '0; cap_wd = '0; cap_addr = '0; fp_m0 = 0; fp_m1 = 0;

        fork
            forever begin
                @(posedge clk);
                #1;
                case (mem_mode)
                    0: begin bus.mem_ready = ($urandom_range(0, 2) != 0); bus.mem_rdata = $urandom; end
                    1: begin bus.mem_ready = 1'b1; bus.mem_rdata = fix_rdata; end
                    2: begin
                        // ready only on the sixth consecutive ACCESS cycle
                        if (bus.mem_en) u0++; else u0 = 0;
                        bus.mem_ready = (u0 >= 6);
                        bus.mem_rdata = fix_rdata;
                    end
                    default: bus.mem_ready = 1'b0;
                endcase
            end
            forever begin
                @(negedge clk);
                if (bus.mem_en) begin
                    en_cnt++;
                    if (prev_en && (bus.mem_be != cap_be || bus.mem_addr != cap_addr ||
                                    bus.mem_wdata != cap_wd)) unstable++;
                    cap_be = bus.mem_be; cap_addr = bus.mem_addr; cap_wd = bus.mem_wdata;
                end
                prev_en = bus.mem_en;
                if (rst_n && fbus.m0_ack) fp_m0++;
                if (rst_n && fbus.m1_ack) fp_m1++;
            end
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    chk("mem_en",    32'(bus.mem_en),    32'(m_busy));
                    chk("mem_be",    32'(bus.mem_be),    m_busy ? 32'(exp_be(t.we, t.size, t.addr)) : 32'h0);
                    chk("mem_addr",  32'(bus.mem_addr),  m_busy ? 32'(t.addr[AW+1:2]) : 32'h0);
                    chk("mem_wdata", bus.mem_wdata,      m_busy ? exp_wrep(t.size, t.wdata) : 32'h0);
                    chk("m0_ack",    32'(bus.m0_ack),    32'(m_reply && t.m == 0));
                    chk("m1_ack",    32'(bus.m1_ack),    32'(m_reply && t.m == 1));
                    chk("m0_err",    32'(bus.m0_err),    32'(m_reply && t.m == 0 && m_err));
                    chk("m1_err",    32'(bus.m1_err),    32'(m_reply && t.m == 1 && m_err));
                    chk("m0_rdata",  bus.m0_rdata,       (m_reply && t.m == 0) ? m_rd : 32'h0);
                    chk("m1_rdata",  bus.m1_rdata,       (m_reply && t.m == 1) ? m_rd : 32'h0);
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_en", 32'(bus.mem_en), 32'h0);
        chk("rst_mem_be", 32'(bus.mem_be), 32'h0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_acks", {30'h0, bus.m1_ack, bus.m0_ack}, 32'h0);
        chk("rst_rdata", bus.m0_rdata | bus.m1_rdata, 32'h0);
        #1 rst_n = 1'b1;

        // Byte store at addr 3
        e0 = en_cnt;
        drive(0, 1'b1, 2'd0, 1'b0, 32'h0000_0003, 32'h0000_00A5);
        wait_ack(0, lat, err, rd);
        chk("sb_latency", lat, 2);
        chk("sb_err", 32'(err), 32'h0);
        chk("sb_be", 32'(cap_be), 32'h8);
        chk("sb_wdata", cap_wd, 32'hA5A5_A5A5);
        chk("sb_addr", 32'(cap_addr), 32'h0);
        chk("sb_en_cycles", en_cnt - e0, 1);

        // Half loads with and without sign extension
        fix_rdata = 32'h8001_7FFF;
        drive(1, 1'b0, 2'd1, 1'b1, 32'h0000_0012, 32'h0);
        wait_ack(1, lat, err, rd);
        chk("lh_sext", rd, 32'hFFFF_8001);
        drive(1, 1'b0, 2'd1, 1'b0, 32'h0000_0012, 32'h0);
        wait_ack(1, lat, err, rd);
        chk("lh_zext", rd, 32'h0000_8001);
        drive(0, 1'b0, 2'd0, 1'b1, 32'h0000_0001, 32'h0);
        wait_ack(0, lat, err, rd);
        chk("lb_sext", rd, 32'h0000_007F);

        // Illegal requests never touch memory
        e0 = en_cnt;
        drive(0, 1'b1, 2'd2, 1'b0, 32'h0000_0006, 32'hDEAD_BEEF);
        wait_ack(0, lat, err, rd);
        chk("ill_word_latency", lat, 1);
        chk("ill_word_err", 32'(err), 32'h1);
        drive(0, 1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0);
        wait_ack(0, lat, err, rd);
        chk("ill_size_latency", lat, 1);
        chk("ill_size_err", 32'(err), 32'h1);
        chk("ill_no_mem_en", en_cnt - e0, 0);

        // Five wait states
        mem_mode = 2;
        e0 = en_cnt;
        u0 = unstable;
        drive(0, 1'b1, 2'd1, 1'b0, 32'h0000_0046, 32'h0000_BEEF);
        wait_ack(0, lat, err, rd);
        chk("wait_latency", lat, 7);
        chk("wait_en_cycles", en_cnt - e0, 6);
        chk("wait_stable", unstable - u0, 0);
        chk("wait_be", 32'(cap_be), 32'hC);
        chk("wait_addr", 32'(cap_addr), 32'h11);
        u0 = 0;

        // Reset during ACCESS, then alternation from a fresh pointer
        mem_mode = 3;
        drive(0, 1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bus.mem_en;
        end
        chk("rst_mid_reached_access", 32'(seen), 32'h1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_en", 32'(bus.mem_en), 32'h0);
        chk("rst_mid_ack", {30'h0, bus.m1_ack, bus.m0_ack}, 32'h0);
        bus.m0_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid_no_ack", {30'h0, bus.m1_ack, bus.m0_ack}, 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        mem_mode = 1;
        fix_rdata = 32'hCAFE_F00D;
        bus.m0_we = 1'b0; bus.m0_size = 2'd2; bus.m0_addr = 32'h20; bus.m0_req = 1'b1;
        bus.m1_we = 1'b0; bus.m1_size = 2'd2; bus.m1_addr = 32'h40; bus.m1_req = 1'b1;
        for (int i = 0; i < 40 && log_q.size() < 4; i++) begin
            @(negedge clk);
            if (bus.m0_ack) log_q.push_back(0);
            if (bus.m1_ack) log_q.push_back(1);
        end
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
        chk("alt_count", log_q.size(), 4);
        for (int k = 0; k < log_q.size(); k++) chk($sformatf("alt_grant%0d", k), log_q[k], k % 2);

        // Randomized traffic from both masters
        mem_mode = 0;
        @(posedge clk);
        fork
            rand_master(0, 80);
            rand_master(1, 80);
        join
        repeat (4) @(posedge clk);

        // Fixed-priority instance saw both masters requesting the whole time
        chk("fp_m1_starved", fp_m1, 0);
        chk("fp_m0_served", 32'(fp_m0 > 20), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
